dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Load/store sequencer between the pipeline's memory stage and the word-wide (32-bit, 8K-word) data memory.
- Converts byte/halfword/word requests on a byte address into word accesses.
- Sign-/zero-extends loads; performs read-modify-write for sub-word stores.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 13, data-memory word-address width; byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned/illegal; valid with resp_valid.
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2].
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  memory read word; valid the cycle after mem_re.

Behaviour:
- Reset (asynchronous, reset low):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_err, mem_re, mem_we = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
  - Reset mid-operation aborts the in-flight access; a pending RMW write is never issued.
- Handshake:
  - Accept when req_valid && req_ready; all request fields are latched.
  - req_ready=0 in every state except IDLE.
  - No response backpressure.
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE, on accept:
  - Error (size 11, half with addr[0]=1, word with addr[1:0]!=0): go to RESP with resp_err=1.
  - Load or sub-word store: go to READ.
  - Word store: go to WRITE.
- READ: mem_re=1 for exactly one cycle, mem_addr driven; go to CAPTURE.
- CAPTURE: sample mem_rdata.
  - Load: select lane, extend, go to RESP.
  - Store: merge lanes, go to WRITE.
- WRITE: mem_we=1 for exactly one cycle with mem_addr and mem_wdata; go to RESP.
- RESP: resp_valid=1 for one cycle; go to IDLE, where req_ready=1 that same cycle.
- Byte lanes are little-endian:
  - Byte n (addr[1:0]=n) occupies bits 8n+7:8n.
  - Halfword at addr[1]=h occupies bits 16h+15:16h.
- Merge: only the selected lane(s) take req_wdata[7:0] / [15:0]; other bits keep the CAPTURE value.
- Latency, accept cycle = 0, resp_valid at:
  - Load: cycle 3.
  - Word store: cycle 2.
  - Sub-word store: cycle 4.
  - Error: cycle 1.
- Throughput: back-to-back requests are accepted in the resp_valid cycle.
- mem_re and mem_we are never high together; both are 0 outside READ/WRITE.
- Memory side: write commits on the clk edge ending the WRITE cycle; read data is registered by the memory, one cycle after mem_re.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined:
  - Adds ports clear_req (in, 1) and clear_done (out, 1, pulse).
  - clear_req sampled in IDLE takes priority over req_valid and enters state CLEAR.
  - CLEAR asserts mem_we=1, mem_wdata=0, with an ADDR_W-bit counter walking mem_addr 0..2^ADDR_W-1, one word per cycle.
  - clear_done pulses one cycle after the last write, then the FSM returns to IDLE.
  - req_ready=0 throughout CLEAR.
  - Reset during CLEAR aborts and zeroes the counter.
- Undefined: ports and state are absent; memory contents are untouched by the controller.

Test Plan:
- Word store 0xAAAAAAAA at byte addr 100, then word load at 100:
  - mem_we pulse with mem_addr=25.
  - resp_rdata=0xAAAAAAAA at cycle 3.
  - resp_err=0.
- Memory word 25 = 0x11223344; sb 0xFF at addr 101:
  - READ, CAPTURE, then WRITE with mem_wdata=0x1122FF44.
  - resp_valid at cycle 4.
- Memory word 25 = 0x8000F0F0:
  - lh at 102, signed: resp_rdata=0xFFFF8000.
  - lhu at 102: 0x00008000.
  - lb at 100: 0xFFFFFFF0.
  - lbu at 100: 0x000000F0.
- lw at 102, sh at 101, size=11 at 100:
  - Each gives resp_valid with resp_err=1 at cycle 1.
  - mem_re=mem_we=0 throughout.
- Sub-word store accepted; reset driven low during CAPTURE:
  - All outputs 0 immediately.
  - No mem_we pulse ever occurs.
  - req_ready=1 after release.
- With DMEM_CLEAR_EN and ADDR_W=4, pulse clear_req:
  - 16 consecutive mem_we cycles, mem_addr 0..15, mem_wdata=0.
  - clear_done one cycle later.
  - A request held during CLEAR is accepted only after clear_done.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the memory stage and a word-wide data memory.
// Optional DMEM_CLEAR_EN adds a clear_req/clear_done memory-zeroing sweep.
module dmem_access_ctrl #(
   parameter int unsigned ADDR_W = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
`ifdef DMEM_CLEAR_EN
   ,
   input  logic              clear_req,
   output logic              clear_done
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      WRITE,
      RESP
`ifdef DMEM_CLEAR_EN
      ,
      CLEAR,
      CLEAR_DONE
`endif
   } state_e;

   state_e            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;
   logic [15:0]       wdata_q, wdata_d;
`ifdef DMEM_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              clear_done_q, clear_done_d;
`endif

   logic        req_err;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] ld_data;
   logic [31:0] st_merge;

   assign req_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // Little-endian lane extraction and merge on the captured memory word.
   always_comb begin
      rd_byte = mem_rdata[7:0];
      case (off_q)
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         2'd3:    rd_byte = mem_rdata[31:24];
         default: rd_byte = mem_rdata[7:0];
      endcase
      rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'b00:   ld_data = {{24{~uns_q & rd_byte[7]}}, rd_byte};
         2'b01:   ld_data = {{16{~uns_q & rd_half[15]}}, rd_half};
         default: ld_data = mem_rdata;
      endcase
      st_merge = mem_rdata;
      if (size_q == 2'b00) begin
         case (off_q)
            2'd1:    st_merge[15:8]  = wdata_q[7:0];
            2'd2:    st_merge[23:16] = wdata_q[7:0];
            2'd3:    st_merge[31:24] = wdata_q[7:0];
            default: st_merge[7:0]   = wdata_q[7:0];
         endcase
      end else if (off_q[1]) begin
         st_merge[31:16] = wdata_q;
      end else begin
         st_merge[15:0] = wdata_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      mem_addr_d   = mem_addr_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
`ifdef DMEM_CLEAR_EN
      clr_cnt_d    = clr_cnt_q;
      clear_done_d = 1'b0;
`endif
      case (state_q)
         // RESP doubles as an idle cycle so a new request can be taken back-to-back.
         IDLE, RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
`ifdef DMEM_CLEAR_EN
            if (clear_req) begin
               state_d     = CLEAR;
               req_ready_d = 1'b0;
               clr_cnt_d   = '0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               mem_we_d    = 1'b1;
            end else
`endif
            if (req_valid) begin
               we_d       = req_we;
               size_d     = req_size;
               uns_d      = req_unsigned;
               off_d      = req_addr[1:0];
               wdata_d    = req_wdata[15:0];
               mem_addr_d = req_addr[ADDR_W+1:2];
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (!req_we || req_size != 2'b10) begin
                  state_d     = READ;
                  req_ready_d = 1'b0;
                  mem_re_d    = 1'b1;
               end else begin
                  state_d     = WRITE;
                  req_ready_d = 1'b0;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = req_wdata;
               end
            end
         end
         READ: state_d = CAPTURE;
         CAPTURE: begin
            if (!we_q) begin
               state_d      = RESP;
               req_ready_d  = 1'b1;
               resp_valid_d = 1'b1;
               resp_rdata_d = ld_data;
            end else begin
               state_d     = WRITE;
               mem_we_d    = 1'b1;
               mem_wdata_d = st_merge;
            end
         end
         WRITE: begin
            state_d      = RESP;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b1;
         end
`ifdef DMEM_CLEAR_EN
         CLEAR: begin
            if (clr_cnt_q == '1) begin
               state_d      = CLEAR_DONE;
               clear_done_d = 1'b1;
            end else begin
               clr_cnt_d  = clr_cnt_q + 1'b1;
               mem_addr_d = clr_cnt_q + 1'b1;
               mem_we_d   = 1'b1;
            end
         end
         CLEAR_DONE: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
`endif
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         we_q         <= 1'b0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         off_q        <= '0;
         wdata_q      <= '0;
`ifdef DMEM_CLEAR_EN
         clr_cnt_q    <= '0;
         clear_done_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
`ifdef DMEM_CLEAR_EN
         clr_cnt_q    <= clr_cnt_d;
         clear_done_q <= clear_done_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_re     = mem_re_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;
`ifdef DMEM_CLEAR_EN
   assign clear_done = clear_done_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected responses and memory
// accesses are queued at issue time and popped by a negedge monitor.
module tb_dmem_access_ctrl;

   localparam int unsigned AW = 13;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]    req_size;
   logic [AW+1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid, resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_re, mem_we;
   logic [31:0]   mem_wdata, mem_rdata;

   logic [31:0] mem [0:(1<<AW)-1];
   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   typedef struct { logic [31:0] rd; logic err; int due; } resp_t;
   typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
   resp_t          sq[$];
   wr_t            wq[$];
   logic [AW-1:0]  rq[$];

   dmem_access_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   always @(negedge clk) begin
      if (resp_valid) begin
         if (sq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
         else begin
            resp_t e;
            e = sq.pop_front();
            chk("resp_rdata", resp_rdata, e.rd);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            chk("resp_latency", cyc, e.due);
         end
      end
      if (mem_re || mem_we) chk("re_we_exclusive", {31'b0, mem_re & mem_we}, 32'd0);
      if (mem_we) begin
         if (wq.size() == 0) chk("unexpected_mem_we", 32'd1, 32'd0);
         else begin
            wr_t w;
            w = wq.pop_front();
            chk("mem_we_addr", {19'b0, mem_addr}, {19'b0, w.addr});
            chk("mem_wdata", mem_wdata, w.data);
         end
      end
      if (mem_re) begin
         if (rq.size() == 0) chk("unexpected_mem_re", 32'd1, 32'd0);
         else chk("mem_re_addr", {19'b0, mem_addr}, {19'b0, rq.pop_front()});
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW+1:0] addr, input logic [31:0] wdata,
                        input bit push, input logic [31:0] exp_rd,
                        input logic exp_err, input int lat);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_size = size;
      req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
      else if (push) sq.push_back('{exp_rd, exp_err, cyc + lat});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic poke(input logic [AW-1:0] waddr, input logic [31:0] data);
      wq.push_back('{waddr, data});
      issue(1'b1, 2'b10, 1'b0, {waddr, 2'b00}, data, 1'b1, 32'd0, 1'b0, 2);
   endtask

   task automatic load(input logic [1:0] size, input logic uns,
                       input logic [AW+1:0] addr, input logic [31:0] exp);
      rq.push_back(addr[AW+1:2]);
      issue(1'b0, size, uns, addr, 32'd0, 1'b1, exp, 1'b0, 3);
   endtask

   task automatic sub_store(input logic [1:0] size, input logic [AW+1:0] addr,
                            input logic [31:0] wdata, input logic [31:0] merged);
      rq.push_back(addr[AW+1:2]);
      wq.push_back('{addr[AW+1:2], merged});
      issue(1'b1, size, 1'b0, addr, wdata, 1'b1, 32'd0, 1'b0, 4);
   endtask

   task automatic bad(input logic we, input logic [1:0] size, input logic [AW+1:0] addr);
      issue(we, size, 1'b0, addr, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b1, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sq.size() + wq.size() + rq.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if ((sq.size() + wq.size() + rq.size()) != 0) chk("drain_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_mem_re"}, {31'b0, mem_re}, 32'd0);
      chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, {19'b0, mem_addr}, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b1;
      @(negedge clk);

      // word store then word load at byte 100 (word 25)
      poke(13'd25, 32'hAAAA_AAAA);
      load(2'b10, 1'b0, 15'd100, 32'hAAAA_AAAA);

      // sb 0xFF at 101 into 0x11223344
      poke(13'd25, 32'h1122_3344);
      sub_store(2'b00, 15'd101, 32'h1234_56FF, 32'h1122_FF44);
      load(2'b10, 1'b0, 15'd100, 32'h1122_FF44);

      // lane select and extension on 0x8000F0F0
      poke(13'd25, 32'h8000_F0F0);
      load(2'b01, 1'b0, 15'd102, 32'hFFFF_8000);
      load(2'b01, 1'b1, 15'd102, 32'h0000_8000);
      load(2'b00, 1'b0, 15'd100, 32'hFFFF_FFF0);
      load(2'b00, 1'b1, 15'd100, 32'h0000_00F0);
      load(2'b00, 1'b0, 15'd103, 32'hFFFF_FF80);
      load(2'b01, 1'b0, 15'd100, 32'hFFFF_F0F0);
      load(2'b01, 1'b1, 15'd100, 32'h0000_F0F0);

      // sub-word merges into the other lanes
      sub_store(2'b01, 15'd102, 32'h7777_BEEF, 32'hBEEF_F0F0);
      sub_store(2'b00, 15'd103, 32'h0000_005A, 32'h5AEF_F0F0);
      load(2'b00, 1'b1, 15'd101, 32'h0000_00F0);
      sub_store(2'b00, 15'd102, 32'hFFFF_FF01, 32'h5A01_F0F0);
      load(2'b10, 1'b0, 15'd100, 32'h5A01_F0F0);

      // top word of memory
      poke(13'd8191, 32'hCAFE_BABE);
      load(2'b00, 1'b1, 15'd32766, 32'h0000_00FE);
      sub_store(2'b01, 15'd32764, 32'h0000_1234, 32'hCAFE_1234);
      load(2'b01, 1'b0, 15'd32766, 32'hFFFF_CAFE);

      // illegal / misaligned: error pulse at cycle 1, no memory access
      bad(1'b0, 2'b10, 15'd102);
      bad(1'b1, 2'b01, 15'd101);
      bad(1'b0, 2'b11, 15'd100);
      bad(1'b0, 2'b01, 15'd103);
      bad(1'b1, 2'b10, 15'd101);
      wait_idle();

      // reset asserted during CAPTURE of a sub-word store: no write ever issues
      rq.push_back(13'd25);
      issue(1'b1, 2'b00, 1'b0, 15'd100, 32'h0000_0055, 1'b0, 32'd0, 1'b0, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_reset_outputs("abort");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_abort_ready", {31'b0, req_ready}, 32'd1);
      load(2'b10, 1'b0, 15'd100, 32'h5A01_F0F0);
      wait_idle();

      chk("resp_queue_empty", sq.size(), 32'd0);
      chk("write_queue_empty", wq.size(), 32'd0);
      chk("read_queue_empty", rq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
